// File: rtl/decode_stage.sv
// Registered decode stage with integrated register file and valid/ready handshake.
// Optional macro DECODE_BYPASS_EN forwards same-cycle write-back data into the operands.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_1,
  output logic [XLEN-1:0] operand_2,
  output logic [XLEN-1:0] immediate_value,
  output logic [4:0]      destination_reg,
  output logic [3:0]      alu_control,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [5:0] NumRegsW = 6'(NUM_REGS);

  // Register 0 and addresses beyond NUM_REGS are hard-wired to zero.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NumRegsW);
  endfunction

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic            accept;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rd_rs, rd_rt;
  logic [3:0]      dec_alu;
  logic [4:0]      dec_dst;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rw, dec_ill;

  logic            valid_q;
  logic [XLEN-1:0] op1_q, op2_q, imm_q;
  logic [4:0]      dst_q;
  logic [3:0]      alu_q;
  logic            rw_q, ill_q;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = instr[15:0];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && addr_ok(wb_addr)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd_rs = addr_ok(rs) ? rf_q[rs] : '0;
    rd_rt = addr_ok(rt) ? rf_q[rt] : '0;
`ifdef DECODE_BYPASS_EN
    if (wb_en && addr_ok(wb_addr) && (wb_addr == rs)) rd_rs = wb_data;
    if (wb_en && addr_ok(wb_addr) && (wb_addr == rt)) rd_rt = wb_data;
`endif
  end

  always_comb begin
    dec_alu = 4'd0;
    dec_dst = 5'd0;
    dec_imm = '0;
    dec_rw  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      6'b000000: begin
        dec_alu = 4'b0001;
        dec_dst = rd;
        dec_rw  = 1'b1;
      end
      6'b000001: begin
        dec_alu = 4'b0010;
        dec_dst = rt;
        dec_imm = {{(XLEN-16){imm[15]}}, imm};
        dec_rw  = 1'b1;
      end
      6'b000010: begin
        dec_imm = {{(XLEN-16){imm[15]}}, imm};
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Flush drops both the held bundle and anything accepted this cycle; fields keep old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      dst_q   <= '0;
      alu_q   <= '0;
      rw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      op1_q   <= rd_rs;
      op2_q   <= rd_rt;
      imm_q   <= dec_imm;
      dst_q   <= dec_dst;
      alu_q   <= dec_alu;
      rw_q    <= dec_rw;
      ill_q   <= dec_ill;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid       = valid_q;
  assign operand_1       = op1_q;
  assign operand_2       = op2_q;
  assign immediate_value = imm_q;
  assign destination_reg = dst_q;
  assign alu_control     = alu_q;
  assign reg_write       = rw_q;
  assign illegal         = ill_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage with an integrated register file, valid/ready handshake, flush, and optional write-back bypass. It sits between the fetch stage and the ALU/execute stage. It accepts one 32-bit instruction per cycle and presents decoded operands and control one cycle later. It owns the architectural register file, which the write-back stage updates through a dedicated write port.

## Interface
- XLEN, 32: data-path width of register-file entries and operands.
- NUM_REGS, 32: number of architectural registers; legal range 2..32; register address width is 5 bits regardless.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `instr` holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  instruction; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- flush  input  1  discard the instruction held in the output register and any instruction accepted this cycle.
- wb_en  input  1  register-file write enable.
- wb_addr  input  5  write address.
- wb_data  input  XLEN  write data.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute stage consumes the bundle.
- operand_1  output  XLEN  regfile[rs].
- operand_2  output  XLEN  regfile[rt].
- immediate_value  output  XLEN  imm sign-extended to XLEN.
- destination_reg  output  5  destination register index.
- alu_control  output  4  ALU operation code.
- reg_write  output  1  write-back required.
- illegal  output  1  opcode not recognised.

## Operation
- Register file: NUM_REGS × XLEN entries.
  - Entry 0 always reads 0; writes to address 0 are ignored.
  - Addresses ≥ NUM_REGS read 0, and writes to them are ignored.
  - Write happens on clk when wb_en=1. Write-back writes are never blocked by stall or flush.
- Decode table (combinational on `instr`, captured into the output register on accept):
  - 6'b000000 R-type: alu_control=4'b0001, destination_reg=rd, immediate_value=0, reg_write=1.
  - 6'b000001 I-type: alu_control=4'b0010, destination_reg=rt, immediate_value=sext(imm), reg_write=1.
  - 6'b000010 J-type: alu_control=4'b0000, destination_reg=0, immediate_value=sext(imm), reg_write=0.
  - Any other opcode: alu_control=0, destination_reg=0, immediate_value=0, reg_write=0, illegal=1.
  - operand_1/operand_2 are always read from rs/rt, for every opcode.
- Handshake:
  - in_ready = !out_valid || out_ready, regardless of flush.
  - Accept when in_valid && in_ready.
  - Bundle is held stable while out_valid && !out_ready.
- Flush:
  - Next cycle: out_valid=0.
  - An instruction accepted in the flush cycle is consumed and dropped.
  - Bundle fields keep their previous values while out_valid=0.

## Timing
- Latency 1: an instruction accepted at edge N appears with out_valid=1 after edge N.
- Throughput 1/cycle when out_ready=1.
- Reset (synchronous, one cycle of rst=1):
  - out_valid=0, operand_1=0, operand_2=0, immediate_value=0, destination_reg=0, alu_control=0, reg_write=0, illegal=0.
  - All register-file entries are cleared to 0.
  - in_ready=1 once rst is released.
  - rst overrides flush, accept and wb_en in the same cycle.
- Output register update priority: rst > flush > accept > hold.
- Operand read uses register-file contents before the current-cycle write, unless DECODE_BYPASS_EN forwards it (see Configuration).
- Stall: with out_valid=1 and out_ready=0, all outputs hold.
  - Register-file writes during the stall do not alter the captured operands.

## Configuration
- DECODE_BYPASS_EN, defined: when accepting, the stage forwards wb_data to an operand if wb_en=1, wb_addr==rs (respectively rt), and wb_addr is nonzero and < NUM_REGS. A write and a decode read of the same register in the same cycle therefore yield the new value.
- DECODE_BYPASS_EN, undefined: no forwarding. Same-cycle read returns the old value; the hazard unit must insert one bubble.

## Test plan
- Reset then R-type:
  - Preload r3=32'h0000_1213 and r4=32'h5 via wb, then send instr 32'h0064_2800 (rs=3, rt=4, rd=5).
  - Required next cycle: out_valid=1, operand_1=32'h1213, operand_2=5, destination_reg=5, alu_control=4'b0001, reg_write=1.
- I-type sign extension:
  - Send instr 32'h0422_FFFC (rs=1, rt=2, imm=-4).
  - Required: immediate_value=32'hFFFF_FFFC, destination_reg=2, alu_control=4'b0010.
- Back-pressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0 and outputs stable.
  - Also write wb to r1 during the stall: operand_1 is unchanged.
- Flush:
  - Assert flush with out_valid=1 and in_valid=1.
  - Required next cycle: out_valid=0, and the incoming instruction never appears.
- Same-cycle hazard:
  - wb_en=1, wb_addr=3, wb_data=32'hABCD while decoding rs=3 (old r3=7).
  - Required: operand_1=32'hABCD with DECODE_BYPASS_EN defined, 7 without it.
  - wb_addr=0: operand stays 0 in both builds.
- Illegal opcode 6'b111111:
  - Required: illegal=1, reg_write=0, out_valid=1.
  - rst mid-stall: all outputs 0 the next cycle.
